pc_sequencer: RTL

Parametrised program-counter sequencer for the datapath's fetch stage, the successor to the plain two-way next-address select. It holds the registered PC and picks the next address among sequential, unconditional jump, conditional branch, call, return and hold. Calls push the return address onto an internal return-address stack of configurable depth. The block reports stack status and latches misuse errors.

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/ras_stack.sv | 58 +++++
 rtl/pc_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings and op type.
package pc_seq_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NEXT   = 3'd0;
    localparam op_t OP_JUMP   = 3'd1;
    localparam op_t OP_BRANCH = 3'd2;
    localparam op_t OP_CALL   = 3'd3;
    localparam op_t OP_RET    = 3'd4;
    localparam op_t OP_HOLD   = 3'd5;

    // Codes 6 and 7 are unassigned and treated as misuse by the sequencer.
    function automatic logic op_is_legal(input op_t op);
        return (op <= OP_HOLD);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack. Owns the stack pointer and entry storage.
// The caller guarantees push is never asserted when full and pop is never
// asserted when empty, so no internal guarding is done here.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    // A depth of one still needs a one-bit index.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_m1;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign sp_m1  = sp - SP_ONE;
    assign wr_idx = sp[IDX_W-1:0];
    assign rd_idx = sp_m1[IDX_W-1:0];

    assign top   = mem[rd_idx];
    assign empty = (sp == '0);
    assign full  = (sp == SP_MAX);

    // Stack pointer: grows on push, shrinks on pop, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SP_ONE;
        end else if (pop) begin
            sp <= sp_m1;
        end
    end

    // Entry storage; contents are don't-care after reset, so it is not cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with next-address select and a return-address
// stack for call/return. Misuse (illegal op, overflow, underflow) sets a
// sticky error flag that only reset clears.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  op_t               op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              err
);

    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic              push;
    logic              pop;
    logic              err_set;

    // Carry out is dropped so the address wraps to zero.
    assign seq_addr = pc + ADDR_W'(1);

    ras_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq_addr),
        .top       (ras_top),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    // Next-PC select and stack requests; push/pop are gated by full/empty here.
    always_comb begin
        pc_next = pc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (en) begin
            if (!op_is_legal(op)) begin
                err_set = 1'b1;
            end else if (op == OP_NEXT) begin
                pc_next = seq_addr;
            end else if (op == OP_JUMP) begin
                pc_next = jump_addr;
            end else if (op == OP_BRANCH) begin
                pc_next = cond ? jump_addr : seq_addr;
            end else if (op == OP_CALL) begin
                if (stack_full) begin
                    err_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    pc_next = jump_addr;
                end
            end else if (op == OP_RET) begin
                if (stack_empty) begin
                    err_set = 1'b1;
                end else begin
                    pop     = 1'b1;
                    pc_next = ras_top;
                end
            end
        end
    end

    // Registered PC and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_ADDR;
            err <= 1'b0;
        end else begin
            pc  <= pc_next;
            err <= err | err_set;
        end
    end

endmodule
